full_adder_cla: RTL and testbench

//  Carry-lookahead adder: sum/cout = a + b + cin, built from per-bit propagate/generate with grouped lookahead.

---
 rtl/full_adder_cla.sv | 136 +++++++++++++
 tb/tb_full_adder_cla.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/full_adder_cla.sv
// rtl/full_adder_cla.sv - grouped carry-lookahead adder with registered copy
//
// Purpose:
//   sum/cout = a + b + cin. Carries inside a GROUP come from a flattened
//   sum-of-products lookahead. Carries between groups chain through group P/G.
//   WIDTH=1 gives the basic 1-bit full adder. The combinational result drives
//   datapath logic directly. A registered copy with a valid flag feeds
//   pipelined consumers.
//
// Ports:
//   clk_i     in   1      clock, rising edge
//   rst_i     in   1      synchronous active-high reset (registered path only)
//   a_i       in   WIDTH  operand A
//   b_i       in   WIDTH  operand B
//   cin_i     in   1      carry in
//   valid_i   in   1      capture strobe for registered outputs
//   sum_o     out  WIDTH  combinational sum mod 2^WIDTH
//   cout_o    out  1      combinational carry out of MSB
//   sum_q_o   out  WIDTH  registered sum
//   cout_q_o  out  1      registered carry out
//   valid_o   out  1      registered-output valid
module full_adder_cla #(
  parameter int WIDTH = 1,
  parameter int GROUP = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic [WIDTH-1:0] sum_q_o,
  output logic             cout_q_o,
  output logic             valid_o
);

  localparam int NGRP = (WIDTH + GROUP - 1) / GROUP;

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH:0]   w_c;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_valid;

  assign w_p = a_i ^ b_i;
  assign w_g = a_i & b_i;

  // Everything is computed in block-local variables. This keeps the carry
  // vector from being read back while it is still being built.
  always_comb begin : b_cla
    logic [WIDTH:0] v_c;
    logic [NGRP:0]  v_gc;
    logic           v_term;
    logic           v_or;
    logic           v_gp;
    logic           v_gg;
    int             v_lo;

    v_c     = '0;
    v_gc    = '0;
    v_term  = 1'b0;
    v_or    = 1'b0;
    v_gp    = 1'b0;
    v_gg    = 1'b0;
    v_lo    = 0;
    v_gc[0] = cin_i;

    for (int k = 0; k < NGRP; k++) begin
      v_lo      = k * GROUP;
      v_c[v_lo] = v_gc[k];

      // Carry into bit (v_lo+j+1):
      //   OR over m of ( g[m] & p[m+1..v_lo+j] )  |  ( p[v_lo..v_lo+j] & c_in )
      // The final group may be partial; bits at or above WIDTH are skipped,
      // so they contribute nothing.
      for (int j = 0; j < GROUP; j++) begin
        if (v_lo + j < WIDTH) begin
          v_or = 1'b0;
          for (int m = 0; m <= j; m++) begin
            v_term = w_g[v_lo + m];
            for (int n = m + 1; n <= j; n++) begin
              v_term = v_term & w_p[v_lo + n];
            end
            v_or = v_or | v_term;
          end
          v_term = v_gc[k];
          for (int n = 0; n <= j; n++) begin
            v_term = v_term & w_p[v_lo + n];
          end
          v_c[v_lo + j + 1] = v_or | v_term;
        end
      end

      // Group propagate/generate. Only this pair crosses group boundaries.
      v_gp = 1'b1;
      v_gg = 1'b0;
      for (int j = 0; j < GROUP; j++) begin
        if (v_lo + j < WIDTH) begin
          v_gg = w_g[v_lo + j] | (w_p[v_lo + j] & v_gg);
          v_gp = v_gp & w_p[v_lo + j];
        end
      end
      v_gc[k + 1] = v_gg | (v_gp & v_gc[k]);
    end

    w_c = v_c;
  end

  assign sum_o  = w_p ^ w_c[WIDTH-1:0];
  assign cout_o = w_c[WIDTH];

  // Reset takes priority over a capture on the same edge. The sum and carry
  // hold when no capture occurs; only the valid flag drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else if (valid_i) begin
      r_sum   <= sum_o;
      r_cout  <= cout_o;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign sum_q_o  = r_sum;
  assign cout_q_o = r_cout;
  assign valid_o  = r_valid;

endmodule

// File: tb/tb_full_adder_cla.sv
// tb/tb_full_adder_cla.sv - directed self-checking bench for full_adder_cla
module tb_full_adder_cla;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // WIDTH=1 instance
  logic       a1, b1, c1, v1;
  logic       s1, co1, sq1, coq1, vq1;
  // WIDTH=8 instance
  logic [7:0] a8, b8;
  logic       c8, v8;
  logic [7:0] s8, sq8;
  logic       co8, coq8, vq8;
  // WIDTH=7, GROUP=4 instance (partial last group)
  logic [6:0] a7, b7;
  logic       c7, v7;
  logic [6:0] s7, sq7;
  logic       co7, coq7, vq7;

  int n_cmp = 0;
  int n_err = 0;

  full_adder_cla #(.WIDTH(1), .GROUP(4)) u1 (
    .clk_i(clk), .rst_i(rst), .a_i(a1), .b_i(b1), .cin_i(c1), .valid_i(v1),
    .sum_o(s1), .cout_o(co1), .sum_q_o(sq1), .cout_q_o(coq1), .valid_o(vq1)
  );

  full_adder_cla #(.WIDTH(8), .GROUP(4)) u8 (
    .clk_i(clk), .rst_i(rst), .a_i(a8), .b_i(b8), .cin_i(c8), .valid_i(v8),
    .sum_o(s8), .cout_o(co8), .sum_q_o(sq8), .cout_q_o(coq8), .valid_o(vq8)
  );

  full_adder_cla #(.WIDTH(7), .GROUP(4)) u7 (
    .clk_i(clk), .rst_i(rst), .a_i(a7), .b_i(b7), .cin_i(c7), .valid_i(v7),
    .sum_o(s7), .cout_o(co7), .sum_q_o(sq7), .cout_q_o(coq7), .valid_o(vq7)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin : stim
    logic [1:0] tbl [8];
    logic [7:0] exp7;
    tbl[0] = 2'b00; tbl[1] = 2'b10; tbl[2] = 2'b10; tbl[3] = 2'b01;
    tbl[4] = 2'b10; tbl[5] = 2'b01; tbl[6] = 2'b01; tbl[7] = 2'b11;

    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; v1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; v8 = 1'b0;
    a7 = 7'h00; b7 = 7'h00; c7 = 1'b0; v7 = 1'b0;

    // 1. WIDTH=1 exhaustive truth table, expected {sum,cout}
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = 3'(i);
      #1;
      chk($sformatf("w1_tt_%0d", i), 32'({s1, co1}), 32'(tbl[i]));
    end

    // 2. Reset held for 2 cycles, then a 1+1+1 capture
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("w1_rst_sum_q",  32'(sq1),  32'h0);
    chk("w1_rst_cout_q", 32'(coq1), 32'h0);
    chk("w1_rst_valid",  32'(vq1),  32'h0);
    chk("w8_rst_sum_q",  32'(sq8),  32'h0);
    chk("w8_rst_valid",  32'(vq8),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
    @(posedge clk);
    #1;
    chk("w1_cap_sum_q",  32'(sq1),  32'h1);
    chk("w1_cap_cout_q", 32'(coq1), 32'h1);
    chk("w1_cap_valid",  32'(vq1),  32'h1);
    @(negedge clk);
    v1 = 1'b0;

    // 3. WIDTH=8 combinational corner cases
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; #1;
    chk("w8_wrap", 32'({co8, s8}), 32'h100);
    a8 = 8'h7F; b8 = 8'h00; c8 = 1'b1; #1;
    chk("w8_7f_cin", 32'({co8, s8}), 32'h080);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; #1;
    chk("w8_max", 32'({co8, s8}), 32'h1FF);
    a8 = 8'h0F; b8 = 8'h01; c8 = 1'b0; #1;
    chk("w8_grp_cross", 32'({co8, s8}), 32'h010);

    // 4. Capture 0x5A, then hold while valid_i is low
    @(negedge clk);
    a8 = 8'h2D; b8 = 8'h2D; c8 = 1'b0; v8 = 1'b1;
    @(posedge clk);
    #1;
    chk("w8_cap_5a",   32'(sq8), 32'h5A);
    chk("w8_cap_vld",  32'(vq8), 32'h1);
    @(negedge clk);
    v8 = 1'b0; a8 = 8'hFF; b8 = 8'h01;
    @(posedge clk);
    #1;
    chk("w8_hold_sum",  32'(sq8),  32'h5A);
    chk("w8_hold_cout", 32'(coq8), 32'h0);
    chk("w8_hold_vld",  32'(vq8),  32'h0);
    chk("w8_comb_track", 32'({co8, s8}), 32'h100);

    // 5. Reset and valid on the same edge: reset wins
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h20; c8 = 1'b1; v8 = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    chk("w8_rstv_sum",  32'(sq8),  32'h0);
    chk("w8_rstv_cout", 32'(coq8), 32'h0);
    chk("w8_rstv_vld",  32'(vq8),  32'h0);
    chk("w8_rstv_comb", 32'({co8, s8}), 32'h111);
    @(negedge clk);
    rst = 1'b0; v8 = 1'b0;

    // 6. WIDTH=7, GROUP=4: directed edges, then random vectors
    a7 = 7'h7F; b7 = 7'h00; c7 = 1'b1; #1;
    chk("w7_ripple_all", 32'({co7, s7}), 32'h080);
    a7 = 7'h40; b7 = 7'h40; c7 = 1'b0; #1;
    chk("w7_msb_carry", 32'({co7, s7}), 32'h080);
    a7 = 7'h07; b7 = 7'h01; c7 = 1'b0; #1;
    chk("w7_into_partial", 32'({co7, s7}), 32'h008);
    for (int i = 0; i < 1000; i++) begin
      a7 = 7'($urandom_range(0, 127));
      b7 = 7'($urandom_range(0, 127));
      c7 = 1'($urandom_range(0, 1));
      #1;
      exp7 = 8'(a7) + 8'(b7) + 8'(c7);
      chk($sformatf("w7_rand_%0d", i), 32'({co7, s7}), 32'(exp7));
    end

    // Registered path on the partial-group instance
    @(negedge clk);
    a7 = 7'h7F; b7 = 7'h7F; c7 = 1'b1; v7 = 1'b1;
    @(posedge clk);
    #1;
    chk("w7_reg", 32'({vq7, coq7, sq7}), 32'h1FF);
    @(negedge clk);
    v7 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
